// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the multi-channel clock divider.
package clk_div_pkg;

    // Default divisor width in bits.
    localparam int DIV_W_DEFAULT = 16;

    // Divisor loaded into every channel at reset (DEFAULT_DIV).
    localparam int DEFAULT_DIV_VALUE = 2;

    // Smallest divisor that keeps a channel running; anything below disables it.
    localparam int MIN_DIV = 2;

    // Width of a channel index; never narrower than one bit.
    function automatic int ch_idx_w(input int num_ch);
        return (num_ch <= 1) ? 1 : $clog2(num_ch);
    endfunction

endpackage

// File: rtl/clk_div_if.sv
// Divisor configuration handshake: a write is accepted on an edge where
// cfg_valid and cfg_ready are both high.
interface clk_div_if #(
    parameter int CH_W  = 2,
    parameter int DIV_W = 16
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [CH_W-1:0]  cfg_ch;
    logic [DIV_W-1:0] cfg_div;

    modport master (output cfg_valid, output cfg_ch, output cfg_div, input cfg_ready);
    modport slave  (input cfg_valid, input cfg_ch, input cfg_div, output cfg_ready);
endinterface

// File: rtl/clk_div_ch.sv
// One divider channel: current divisor, phase counter, one pending-divisor
// slot, and registered clk_out/clk_en derived from the next counter value so
// that counter and outputs change on the same edge.
module clk_div_ch
    import clk_div_pkg::*;
#(
    parameter int DIV_W       = DIV_W_DEFAULT,
    parameter int DEFAULT_DIV = DEFAULT_DIV_VALUE
) (
    input  logic             memclk,
    input  logic             reset,
    input  logic             sync,
    input  logic             wr_en,
    input  logic [DIV_W-1:0] wr_div,
    output logic             clk_out,
    output logic             clk_en,
    output logic             active,
    output logic             pend_valid
);

    localparam logic [DIV_W-1:0] MIN_D = DIV_W'(MIN_DIV);
    localparam logic [DIV_W-1:0] DEF_D = DIV_W'(DEFAULT_DIV);

    logic [DIV_W-1:0] div_reg, div_next;
    logic [DIV_W-1:0] cnt_reg, cnt_next;
    logic [DIV_W-1:0] pend_div_reg, pend_div_next;
    logic             pend_valid_reg, pend_valid_next;
    logic             run_reg;
    logic             clk_out_reg, clk_out_next;
    logic             clk_en_reg, clk_en_next;
    logic             boundary;
    logic             en_next;

    // Next-state: restart the period at a boundary (wrap, sync, first edge
    // after reset, or while disabled), picking up any pending divisor there.
    always_comb begin
        div_next        = div_reg;
        cnt_next        = cnt_reg;
        pend_div_next   = pend_div_reg;
        pend_valid_next = pend_valid_reg;
        boundary        = 1'b0;
        en_next         = 1'b0;
        clk_out_next    = 1'b0;
        clk_en_next     = 1'b0;

        if (!run_reg || sync || (div_reg < MIN_D)) begin
            boundary = 1'b1;
        end else if (cnt_reg == div_reg - 1'b1) begin
            boundary = 1'b1;
        end

        if (boundary) begin
            if (pend_valid_reg) begin
                div_next        = pend_div_reg;
                pend_valid_next = 1'b0;
            end
            cnt_next = '0;
        end else begin
            cnt_next = cnt_reg + 1'b1;
        end

        // A write can only be accepted while the slot is empty, so it never
        // collides with the apply above on the same edge.
        if (wr_en) begin
            pend_div_next   = wr_div;
            pend_valid_next = 1'b1;
        end

        en_next = (div_next >= MIN_D);
        if (!en_next) begin
            cnt_next = '0;
        end
        clk_out_next = en_next && (cnt_next < (div_next >> 1));
        clk_en_next  = en_next && (cnt_next == '0);
    end

    // State register with synchronous reset.
    always_ff @(posedge memclk) begin
        if (reset) begin
            div_reg        <= DEF_D;
            cnt_reg        <= '0;
            pend_div_reg   <= '0;
            pend_valid_reg <= 1'b0;
            run_reg        <= 1'b0;
            clk_out_reg    <= 1'b0;
            clk_en_reg     <= 1'b0;
        end else begin
            div_reg        <= div_next;
            cnt_reg        <= cnt_next;
            pend_div_reg   <= pend_div_next;
            pend_valid_reg <= pend_valid_next;
            run_reg        <= 1'b1;
            clk_out_reg    <= clk_out_next;
            clk_en_reg     <= clk_en_next;
        end
    end

    assign clk_out    = clk_out_reg;
    assign clk_en     = clk_en_reg;
    assign active     = (div_reg >= MIN_D);
    assign pend_valid = pend_valid_reg;

endmodule

// File: rtl/clk_div_gen.sv
// Multi-channel clock divider: decodes divisor writes to channels, derives
// cfg_ready from the addressed channel's pending slot, fans sync out.
module clk_div_gen
    import clk_div_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int DIV_W       = DIV_W_DEFAULT,
    parameter int DEFAULT_DIV = DEFAULT_DIV_VALUE
) (
    input  logic              memclk,
    input  logic              reset,
    input  logic              sync,
    clk_div_if.slave          cfg,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] clk_en,
    output logic [NUM_CH-1:0] active
);

    localparam int CH_W   = ch_idx_w(NUM_CH);
    localparam int PAD_CH = 1 << CH_W;

    logic [NUM_CH-1:0] pend_valid;
    logic [NUM_CH-1:0] wr_en;
    logic [PAD_CH-1:0] busy_pad;
    logic              cfg_ready_int;

    genvar gi;

    // Busy map over the full index space; non-existent channels are never
    // busy, so writes to them are accepted and silently dropped.
    generate
        for (gi = 0; gi < PAD_CH; gi++) begin : g_busy
            if (gi < NUM_CH) begin : g_real
                assign busy_pad[gi] = pend_valid[gi];
            end else begin : g_none
                assign busy_pad[gi] = 1'b0;
            end
        end
    endgenerate

    assign cfg_ready_int = ~busy_pad[cfg.cfg_ch];
    assign cfg.cfg_ready = cfg_ready_int;

    // One divider per channel.
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            assign wr_en[gi] = cfg.cfg_valid && cfg_ready_int && (cfg.cfg_ch == CH_W'(gi));

            clk_div_ch #(
                .DIV_W       (DIV_W),
                .DEFAULT_DIV (DEFAULT_DIV)
            ) u_ch (
                .memclk     (memclk),
                .reset      (reset),
                .sync       (sync),
                .wr_en      (wr_en[gi]),
                .wr_div     (cfg.cfg_div),
                .clk_out    (clk_out[gi]),
                .clk_en     (clk_en[gi]),
                .active     (active[gi]),
                .pend_valid (pend_valid[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_clk_div_gen.sv
// Bench for clk_div_gen: directed scenarios plus random traffic, checked
// against a time-based model (phase = edges since period anchor mod D).
module tb_clk_div_gen;
    import clk_div_pkg::*;

    localparam int NUM_CH = 5;
    localparam int DIV_W  = 16;
    localparam int DEF_D  = 2;
    localparam int CH_W   = ch_idx_w(NUM_CH);

    logic              memclk = 1'b0;
    logic              reset;
    logic              sync;
    logic [NUM_CH-1:0] clk_out;
    logic [NUM_CH-1:0] clk_en;
    logic [NUM_CH-1:0] active;

    clk_div_if #(.CH_W(CH_W), .DIV_W(DIV_W)) cif ();

    clk_div_gen #(
        .NUM_CH      (NUM_CH),
        .DIV_W       (DIV_W),
        .DEFAULT_DIV (DEF_D)
    ) dut (
        .memclk  (memclk),
        .reset   (reset),
        .sync    (sync),
        .cfg     (cif),
        .clk_out (clk_out),
        .clk_en  (clk_en),
        .active  (active)
    );

    always #5 memclk = ~memclk;

    int vectors    = 0;
    int miscompares = 0;

    // Reference model state.
    int m_d     [NUM_CH];
    int m_start [NUM_CH];
    int m_pend  [NUM_CH];
    int m_ph    [NUM_CH];
    bit m_pv    [NUM_CH];
    bit m_first [NUM_CH];
    int n_edge = 0;
    int cyc_no = 0;
    logic [NUM_CH-1:0] e_out, e_en, e_act;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc_no, got, exp);
        end
    endtask

    // Advance the model by one rising edge.
    task automatic model_step(input bit r, input bit s, input bit acc, input int ch, input int dv);
        bit bnd;
        if (r) begin
            for (int i = 0; i < NUM_CH; i++) begin
                m_d[i] = DEF_D; m_pv[i] = 0; m_first[i] = 1; m_ph[i] = 0;
            end
            e_out = '0;
            e_en  = '0;
        end else begin
            n_edge++;
            for (int i = 0; i < NUM_CH; i++) begin
                bnd = m_first[i] || s || (m_d[i] < 2);
                if (!bnd) bnd = (((n_edge - m_start[i]) % m_d[i]) == 0);
                if (bnd) begin
                    if (m_pv[i]) begin
                        m_d[i]  = m_pend[i];
                        m_pv[i] = 0;
                    end
                    m_start[i] = n_edge;
                end
                m_first[i] = 0;
                if (acc && ch == i) begin
                    m_pend[i] = dv;
                    m_pv[i]   = 1;
                end
                if (m_d[i] >= 2) begin
                    m_ph[i]  = (n_edge - m_start[i]) % m_d[i];
                    e_out[i] = (m_ph[i] < m_d[i] / 2);
                    e_en[i]  = (m_ph[i] == 0);
                end else begin
                    m_ph[i]  = 0;
                    e_out[i] = 1'b0;
                    e_en[i]  = 1'b0;
                end
            end
        end
        for (int i = 0; i < NUM_CH; i++) e_act[i] = (m_d[i] >= 2);
    endtask

    // One clock cycle: drive after negedge, check ready, edge, check outputs.
    task automatic cyc(input bit r, input bit s, input bit v, input int ch, input int dv, output bit acc);
        bit er;
        reset         = r;
        sync          = s;
        cif.cfg_valid = v;
        cif.cfg_ch    = ch[CH_W-1:0];
        cif.cfg_div   = dv[DIV_W-1:0];
        #1;
        er = 1'b1;
        if (ch < NUM_CH) er = !m_pv[ch];
        if (!r) chk("ready", {31'b0, cif.cfg_ready}, {31'b0, er});
        acc = v && er && !r;
        @(posedge memclk);
        model_step(r, s, acc, ch, dv);
        #1;
        cyc_no++;
        chk("clk_out", clk_out, e_out);
        chk("clk_en",  clk_en,  e_en);
        chk("active",  active,  e_act);
        $display("cyc %0d rst=%0b sync=%0b wr=%0b ch=%0d d=%0d acc=%0b out=%b en=%b act=%b",
                 cyc_no, r, s, v, ch, dv, acc, clk_out, clk_en, active);
        @(negedge memclk);
    endtask

    task automatic idle(input int count);
        bit acc;
        for (int k = 0; k < count; k++) cyc(0, 0, 0, 0, 0, acc);
    endtask

    task automatic write_hold(input int ch, input int dv);
        bit acc;
        int k;
        acc = 0;
        k = 0;
        while (!acc && k < 64) begin
            cyc(0, 0, 1, ch, dv, acc);
            k++;
        end
        if (!acc) chk("wr_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        bit acc;
        int k;
        reset = 1'b1; sync = 1'b0;
        cif.cfg_valid = 1'b0; cif.cfg_ch = '0; cif.cfg_div = '0;
        @(negedge memclk);

        // Reset, then defaults divide by 2 with phase 0 on first free edge.
        repeat (3) cyc(1, 0, 0, 0, 0, acc);
        chk("rst_out", clk_out, '0);
        cyc(0, 0, 0, 0, 0, acc);
        chk("first_out", clk_out, {NUM_CH{1'b1}});
        chk("first_en",  clk_en,  {NUM_CH{1'b1}});
        idle(6);

        // ch1 -> 5 mid-period.
        idle(1);
        write_hold(1, 5);
        idle(16);

        // ch2 disabled, then re-enabled at 8.
        write_hold(2, 0);
        idle(4);
        chk("ch2_off", {31'b0, active[2]}, 32'd0);
        write_hold(2, 8);
        idle(12);

        // ch0=3, ch3=7, then sync: strobes coincide now and every 21 cycles.
        write_hold(0, 3);
        write_hold(3, 7);
        idle(9);
        cyc(0, 1, 0, 0, 0, acc);
        chk("sync_align", {clk_en[3], clk_en[0]}, 2'b11);
        idle(20);
        cyc(0, 0, 0, 0, 0, acc);
        chk("align21", {clk_en[3], clk_en[0]}, 2'b11);

        // Back-to-back writes to ch1 stall; sync with a write defers it.
        write_hold(1, 6);
        cif.cfg_ch = CH_W'(1);
        #1;
        chk("stall_ready", {31'b0, cif.cfg_ready}, 32'd0);
        write_hold(1, 10);
        idle(14);
        cyc(0, 1, 1, 0, 4, acc);
        idle(8);

        // Reset mid-period of D=9 with a pending write.
        write_hold(3, 9);
        k = 0;
        while (!(m_d[3] == 9 && m_ph[3] == 2) && k < 40) begin
            cyc(0, 0, 0, 0, 0, acc);
            k++;
        end
        if (k >= 40) chk("phase_wait", 32'd0, 32'd1);
        cyc(0, 0, 1, 3, 5, acc);
        cyc(1, 0, 0, 0, 0, acc);
        chk("rst_mid_out", clk_out, '0);
        chk("rst_mid_en",  clk_en,  '0);
        cyc(0, 0, 0, 0, 0, acc);
        chk("rel_out", clk_out, {NUM_CH{1'b1}});
        idle(6);

        // Random traffic, including out-of-range channels and resets.
        for (int t = 0; t < 500; t++) begin
            cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 15) == 0),
                ($urandom_range(0, 2) == 0), $urandom_range(0, (1 << CH_W) - 1),
                $urandom_range(0, 12), acc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/clk_div_gen.md
CLK_DIV_GEN -- requirements
Module: clk_div_gen

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of independent divider channels (1..16).
REQ-002 SHALL have parameter DIV_W, default 16, divisor width in bits.
REQ-003 SHALL have parameter DEFAULT_DIV, default 2, divisor loaded into every channel at reset.
REQ-004 SHALL have port memclk  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port sync  input  1  one-cycle pulse; restarts all enabled channels at phase 0.
REQ-007 SHALL have port cfg_valid  input  1  divisor write request.
REQ-008 SHALL have port cfg_ready  output  1  write accepted when cfg_valid and cfg_ready are high on the same edge.
REQ-009 SHALL have port cfg_ch  input  max(1,clog2(NUM_CH))  target channel.
REQ-010 SHALL have port cfg_div  input  DIV_W  new divisor D.
REQ-011 SHALL have port clk_out  output  NUM_CH  registered divided clock per channel.
REQ-012 SHALL have port clk_en  output  NUM_CH  one-cycle strobe per channel, high in the cycle clk_out rises.
REQ-013 SHALL have port active  output  NUM_CH  channel enabled (current D >= 2).

Function
REQ-014 Each channel SHALL hold current divisor D, counter cnt (0..D-1) and one pending-divisor slot with valid flag.
REQ-015 Enabled channel SHALL produce period of exactly D memclk cycles; clk_out high while cnt < D/2 (floor), low otherwise.
REQ-016 Odd D SHALL give high time (D-1)/2 and low time (D+1)/2 cycles; no half-cycle or negedge logic.
REQ-017 clk_en SHALL be high exactly in cycles where cnt == 0, and clk_out, clk_en, cnt SHALL be updated on the same edge (zero skew between them).
REQ-018 cnt SHALL wrap from D-1 to 0; this edge is the period boundary.
REQ-019 D < 2 SHALL disable the channel: clk_out=0, clk_en=0, active=0, cnt held at 0.
REQ-020 cfg_ready SHALL equal NOT pending_valid[cfg_ch] (combinational on cfg_ch); cfg_ch >= NUM_CH SHALL give cfg_ready=1 and the write SHALL be dropped.
REQ-021 Accepted write SHALL set pending slot; pending value SHALL be applied at the first period boundary strictly after the accepting edge, then pending_valid cleared.
REQ-022 Disabled channel SHALL apply a pending divisor on the edge after acceptance; if new D >= 2 it SHALL start at phase 0 (cnt=0, clk_out=1, clk_en=1) that edge.
REQ-023 Changing D SHALL never truncate the running period: no clk_out pulse shorter than min(old,new) high time.
REQ-024 sync high SHALL force every enabled channel to cnt=0 on the next edge, applying any pending divisor first; channels become phase-aligned.
REQ-025 sync and cfg write in the same cycle: write SHALL go to pending and NOT be applied by that sync.
REQ-026 Writing the same channel repeatedly SHALL stall (cfg_ready=0) until its boundary; other channels unaffected.

Reset
REQ-027 reset SHALL set D=DEFAULT_DIV, cnt=0, pending_valid=0, clk_out=0, clk_en=0 for all channels; active reflects DEFAULT_DIV >= 2.
REQ-028 First edge with reset low SHALL be phase 0 for all enabled channels (clk_out=1, clk_en=1).
REQ-029 reset asserted mid-period SHALL take effect on the next edge, discarding pending writes; outputs low that same edge.

Structure
REQ-030 Package clk_div_pkg SHALL hold DIV_W default, DEFAULT_DIV, MIN_DIV=2 and the channel-index width function.
REQ-031 Per-channel logic SHALL live in sub-module clk_div_ch, instantiated NUM_CH times by a generate loop; top handles cfg decode and sync fan-out.

Verification
REQ-032 Reset release, defaults -> all clk_out toggle every cycle (divide-by-2), clk_en every 2nd cycle, first edge clk_out=1.
REQ-033 Write ch1 D=5 mid-period -> current divide-by-2 period completes, then clk_out[1] high 2, low 3 cycles repeatedly; clk_en[1] period 5.
REQ-034 Write ch2 D=0 then D=8 -> active[2] falls at boundary, outputs low; after second write, phase 0 next edge, high 4/low 4.
REQ-035 ch0 D=3, ch3 D=7 free-running, pulse sync -> next edge both clk_en high together; every 21 cycles coincide thereafter.
REQ-036 Two back-to-back writes ch1 (D=6, D=10) -> cfg_ready low after first until boundary; second applied at following boundary; sync+write same cycle defers write.
REQ-037 reset asserted at cnt=3 of D=9 with pending write -> next edge all outputs 0, pending discarded, D=DEFAULT_DIV after release.
